add_round_key: RTL and testbench

AddRoundKey stage with on-the-fly AES-128 key schedule, sitting directly upstream of `sub_bytes` and driving its `state_ak` input. It expands a loaded 128-bit cipher key into 11 round keys, holds them in a local buffer, and XORs the selected round key into each presented state word. The output is registered with one cycle of latency, matching the registered `sub_bytes` stage downstream.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/key_expand_step.sv | 46 ++++
 rtl/add_round_key.sv | 117 +++++++++++
 tb/tb_add_round_key.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants and types: S-box table, round constants,
//               round count and word/state typedefs.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  // Control states of the add_round_key key-expansion sequencer
  typedef enum logic [1:0] {
    ARK_IDLE   = 2'd0,
    ARK_EXPAND = 2'd1,
    ARK_READY  = 2'd2
  } ark_state_t;

  // Forward S-box, shared with sub_bytes
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants indexed by round number; entry 0 and 11..15 are unused
  // padding so any 4-bit round counter indexes the table safely.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage
`default_nettype wire

// File: rtl/key_expand_step.sv
`default_nettype none
// ============================================================================
// Module      : key_expand_step
// Description : One AES-128 key-schedule step: previous round key and rcon in,
//               next round key out. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  word_t w_w0, w_w1, w_w2, w_w3;
  word_t w_rot;
  word_t w_sub;
  word_t w_temp;
  word_t w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = prev_key[127:96];
  assign w_w1 = prev_key[95:64];
  assign w_w2 = prev_key[63:32];
  assign w_w3 = prev_key[31:0];

  // RotWord: cyclic left rotation by one byte
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  // SubWord: one S-box lookup per byte
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign w_sub[gi*8 +: 8] = SBOX[w_rot[gi*8 +: 8]];
  end

  assign w_temp = w_sub ^ {rcon, 24'h000000};

  // Running XOR across the four words
  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key
// Description : AddRoundKey stage with on-the-fly AES-128 key schedule. Expands
//               a loaded key into NR+1 round keys (one per cycle), stores them,
//               and XORs the selected round key into each accepted state word.
//               Output registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  input  logic [3:0]   round_in,
  output logic [127:0] state_ak,
  output logic         out_valid,
  output logic         round_err
);

  localparam logic [3:0] C_LAST_ROUND = 4'(NR);

  ark_state_t  r_fsm;
  logic [3:0]  r_rcnt;
  state_t      r_rk [0:NR];

  logic [3:0]  w_prev_idx;
  state_t      w_prev_key;
  state_t      w_next_key;
  logic        w_accept;
  logic        w_round_ok;
  state_t      w_rk_sel;

  // All round keys valid exactly while the sequencer sits in READY
  assign key_ready = (r_fsm == ARK_READY);

  // New key always wins over a data beat in the same cycle
  assign w_accept   = in_valid && (r_fsm == ARK_READY) && !key_load;
  assign w_round_ok = (round_in <= C_LAST_ROUND);

  // Source of the next expansion step; guarded so an idle counter of 0 never
  // wraps to an out-of-range buffer index
  assign w_prev_idx = (r_rcnt == 4'd0) ? 4'd0 : (r_rcnt - 4'd1);
  assign w_prev_key = r_rk[w_prev_idx];

  key_expand_step u_key_expand_step (
    .prev_key (w_prev_key),
    .rcon     (RCON[r_rcnt]),
    .next_key (w_next_key)
  );

  // Round-key select for the data path; out-of-range rounds read nothing
  always_comb begin
    w_rk_sel = '0;
    if (w_round_ok) begin
      w_rk_sel = r_rk[round_in];
    end
  end

  // Round-key buffer: key_in lands in slot 0, then one expanded key per cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (key_load) begin
        r_rk[0] <= key_in;
      end else if (r_fsm == ARK_EXPAND) begin
        r_rk[r_rcnt] <= w_next_key;
      end
    end
  end

  // Expansion sequencer: a load (re)starts at round 1, READY after round NR
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm  <= ARK_IDLE;
      r_rcnt <= 4'd0;
    end else if (key_load) begin
      r_fsm  <= ARK_EXPAND;
      r_rcnt <= 4'd1;
    end else begin
      case (r_fsm)
        ARK_EXPAND: begin
          if (r_rcnt == C_LAST_ROUND) begin
            r_fsm <= ARK_READY;
          end else begin
            r_rcnt <= r_rcnt + 4'd1;
          end
        end
        ARK_READY: r_fsm <= ARK_READY;
        default:   r_fsm <= ARK_IDLE;
      endcase
    end
  end

  // Registered data output; state_ak holds its value between accepted beats
  always_ff @(posedge clk) begin
    if (reset) begin
      state_ak  <= '0;
      out_valid <= 1'b0;
      round_err <= 1'b0;
    end else begin
      out_valid <= w_accept;
      round_err <= w_accept && !w_round_ok;
      if (w_accept) begin
        state_ak <= state_in ^ w_rk_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_round_key
// Description : Self-checking bench for add_round_key. Expected results come
//               from a word-level FIPS-197 key schedule whose S-box is derived
//               from GF(2^8) inversion plus the affine map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_round_key;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;
  logic         in_valid;
  logic [127:0] state_in;
  logic [3:0]   round_in;
  logic [127:0] state_ak;
  logic         out_valid;
  logic         round_err;

  int total = 0;
  int bad   = 0;

  logic [128:0] exp_q [$];
  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk   [11];

  localparam logic [127:0] C_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  add_round_key #(.NR(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .state_in  (state_in),
    .round_in  (round_in),
    .state_ak  (state_ak),
    .out_valid (out_valid),
    .round_err (round_err)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine transform
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      end
      m_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented key expansion into 44 words, grouped into 11 round keys
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string nm, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one beat; when accepted, the model result goes on the scoreboard
  task automatic send(input logic [127:0] st, input logic [3:0] rnd, input bit expect_out);
    in_valid = 1'b1;
    state_in = st;
    round_in = rnd;
    if (expect_out) begin
      if (rnd > 4'd10) exp_q.push_back({1'b1, st});
      else             exp_q.push_back({1'b0, st ^ m_rk[rnd]});
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Beat with an explicitly given expected result (known-answer vectors)
  task automatic send_kat(input logic [127:0] st, input logic [3:0] rnd, input logic [127:0] exp);
    in_valid = 1'b1;
    state_in = st;
    round_in = rnd;
    exp_q.push_back({1'b0, exp});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_load(input logic [127:0] key);
    key_load = 1'b1;
    key_in   = key;
    tick();
    key_load = 1'b0;
  endtask

  // Count edges from the load edge until key_ready rises; expect NR
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!key_ready && n < 20) begin
      tick();
      n++;
    end
    check(nm, 129'(n), 129'd10);
  endtask

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h expected no beat", {round_err, state_ak});
      end else begin
        check("beat", {round_err, state_ak}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    key_load = 1'b0;
    key_in   = '0;
    in_valid = 1'b0;
    state_in = '0;
    round_in = '0;
    build_sbox();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset values
    check("rst_key_ready", 129'(key_ready), 129'd0);
    check("rst_out_valid", 129'(out_valid), 129'd0);
    check("rst_round_err", 129'(round_err), 129'd0);
    check("rst_state_ak",  129'(state_ak),  129'd0);

    // Data in IDLE is dropped
    for (int i = 0; i < 3; i++) send(rnd128(), 4'(i), 1'b0);
    check("idle_out_valid", 129'(out_valid), 129'd0);

    // FIPS-197 key, ready exactly NR edges after the load edge
    pulse_load(C_FIPS_KEY);
    check("load_key_ready_low", 129'(key_ready), 129'd0);
    compute_model(C_FIPS_KEY);
    wait_ready("fips_ready_latency");

    // Known-answer beats
    send_kat(128'h3243f6a8885a308d313198a2e0370734, 4'd0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    send_kat(128'h0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
    send_kat(128'h0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Back-to-back sweep across every round key, then out-of-range rounds
    for (int r = 0; r <= 10; r++) send(128'h0, 4'(r), 1'b1);
    send(128'h0123456789abcdeffedcba9876543210, 4'd11, 1'b1);
    send(rnd128(), 4'd15, 1'b1);

    // Random traffic with gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) send(rnd128(), 4'($urandom_range(0, 15)), 1'b1);
      else tick();
    end

    // Restart 4 cycles into expansion; second key must win
    begin
      logic [127:0] ka = rnd128();
      logic [127:0] kb = rnd128();
      pulse_load(ka);
      for (int i = 0; i < 3; i++) tick();
      pulse_load(kb);
      compute_model(kb);
      wait_ready("restart_ready_latency");
      send(128'h0, 4'd10, 1'b1);
      send(rnd128(), 4'd0, 1'b1);
    end

    // Reset mid-expansion aborts it
    pulse_load(rnd128());
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_key_ready", 129'(key_ready), 129'd0);
    check("midrst_out_valid", 129'(out_valid), 129'd0);
    check("midrst_state_ak",  129'(state_ak),  129'd0);
    for (int i = 0; i < 14; i++) tick();
    check("midrst_stays_unready", 129'(key_ready), 129'd0);
    send(rnd128(), 4'd3, 1'b0);

    // Fresh key; then a beat right before a new load uses the old keys,
    // and a beat coincident with the load is dropped
    begin
      logic [127:0] kc = rnd128();
      logic [127:0] kd = rnd128();
      pulse_load(kc);
      compute_model(kc);
      wait_ready("third_ready_latency");
      send(rnd128(), 4'd7, 1'b1);
      send(rnd128(), 4'd4, 1'b1);
      key_load = 1'b1;
      key_in   = kd;
      in_valid = 1'b1;
      state_in = rnd128();
      round_in = 4'd2;
      tick();
      key_load = 1'b0;
      in_valid = 1'b0;
      check("collide_key_ready", 129'(key_ready), 129'd0);
      check("collide_out_valid", 129'(out_valid), 129'd0);
      compute_model(kd);
      wait_ready("collide_ready_latency");
      for (int r = 10; r >= 0; r--) send(rnd128(), 4'(r), 1'b1);
    end

    tick();
    tick();
    check("queue_drained", 129'(exp_q.size()), 129'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
